// File: rtl/rx_fifo.sv
// First-word fall-through receive FIFO fed by a receiver's frame-complete flag.
// Each rising edge of done_flag captures one {error_in, data_in} word.
module rx_fifo #(
   parameter int DEPTH    = 8,
   parameter bit DROP_ERR = 1'b0
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   done_flag,
   input  logic [7:0]             data_in,
   input  logic [2:0]             error_in,
   input  logic                   rd_ready,
   input  logic                   ovf_clr,
   output logic                   rd_valid,
   output logic [7:0]             rd_data,
   output logic [2:0]             rd_err,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   overflow,
   output logic [7:0]             err_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [10:0]   r_mem [DEPTH];
   logic          r_done_q;
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic [7:0]    r_err_cnt;

   logic          w_wr;
   logic          w_err;
   logic          w_keep;
   logic          w_pop;
   logic          w_push;
   logic          w_ovf_set;
   logic [10:0]   w_head;

   assign w_wr   = done_flag & ~r_done_q;
   assign w_err  = |error_in;
   assign w_keep = w_wr & ~(DROP_ERR & w_err);
   assign w_pop  = rd_valid & rd_ready;
   // A full FIFO still accepts a frame when the head leaves in the same cycle.
   assign w_push    = w_keep & (~full | w_pop);
   assign w_ovf_set = w_keep & full & ~w_pop;

   assign w_head   = r_mem[r_rptr];
   assign rd_valid = (r_count != '0);
   assign full     = (r_count == CNT_FULL);
   assign rd_data  = w_head[7:0];
   assign rd_err   = w_head[10:8];
   assign count    = r_count;
   assign overflow = r_overflow;
   assign err_cnt  = r_err_cnt;

   // NOTE: storage has no reset; emptiness is tracked by r_count, so stale words are never shown as valid.
   always_ff @(posedge clock) begin
      if (reset_n && w_push) begin
         r_mem[r_wptr] <= {error_in, data_in};
      end
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_done_q   <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         r_done_q <= done_flag;
         if (w_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
         // A new overflow event takes priority over a coincident clear.
         if (w_ovf_set)    r_overflow <= 1'b1;
         else if (ovf_clr) r_overflow <= 1'b0;
         if (w_wr && w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

endmodule
